// File: rtl/led_fade_driver.sv
// PWM fade stage for the iCEBreaker LEDs: seven on/off requests become linear
// brightness ramps, with pin polarity resolved so upstream logic uses 1 = lit.
module led_fade_driver #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_DIV  = 16,
    parameter int DUTY_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] led_req,
    output logic       ledg_n,
    output logic       ledr_n,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic       led5,
    output logic       fade_busy
);

    localparam int NUM_LEDS = 7;
    localparam int PER_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(DUTY_STEP);
    localparam logic [PER_W-1:0]    PER_MAX  = PER_W'(FADE_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fade_state_t;

    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PER_W-1:0]    per_cnt_reg;
    logic [6:0]          req_q_reg;
    logic                pwm_wrap;
    logic                tick;
    logic [6:0]          lit;
    logic [6:0]          moving;

    logic                ledg_n_reg;
    logic                ledr_n_reg;
    logic [4:0]          led_pmod_reg;
    logic                busy_reg;

    assign pwm_wrap = (pwm_cnt_reg == DUTY_MAX);
    assign tick     = pwm_wrap && (per_cnt_reg == PER_MAX);

    // Shared timebase: PWM counter, fade-period prescaler and request sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= '0;
            per_cnt_reg <= '0;
            req_q_reg   <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            if (pwm_wrap) begin
                per_cnt_reg <= (per_cnt_reg == PER_MAX) ? '0 : per_cnt_reg + 1'b1;
            end
            req_q_reg <= led_req;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            fade_state_t         state_reg;
            fade_state_t         state_next;
            logic [PWM_BITS-1:0] duty_reg;
            logic [PWM_BITS-1:0] duty_next;
            logic [PWM_BITS:0]   duty_up_ext;
            logic [PWM_BITS:0]   duty_dn_ext;
            logic [PWM_BITS-1:0] duty_up;
            logic [PWM_BITS-1:0] duty_dn;

            // The extra top bit is carry on the way up and borrow on the way down.
            always_comb begin
                duty_up_ext = {1'b0, duty_reg} + STEP_EXT;
                duty_dn_ext = {1'b0, duty_reg} - STEP_EXT;
                duty_up     = duty_up_ext[PWM_BITS] ? DUTY_MAX : duty_up_ext[PWM_BITS-1:0];
                duty_dn     = duty_dn_ext[PWM_BITS] ? '0 : duty_dn_ext[PWM_BITS-1:0];
            end

            always_comb begin
                state_next = state_reg;
                duty_next  = duty_reg;
                case (state_reg)
                    ST_OFF: begin
                        if (req_q_reg[gi]) begin
                            state_next = ST_RISE;
                        end
                    end
                    ST_RISE: begin
                        if (!req_q_reg[gi]) begin
                            state_next = ST_FALL;
                        end else if (tick) begin
                            duty_next = duty_up;
                            if (duty_up == DUTY_MAX) begin
                                state_next = ST_ON;
                            end
                        end
                    end
                    ST_ON: begin
                        if (!req_q_reg[gi]) begin
                            state_next = ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        if (req_q_reg[gi]) begin
                            state_next = ST_RISE;
                        end else if (tick) begin
                            duty_next = duty_dn;
                            if (duty_dn == '0) begin
                                state_next = ST_OFF;
                            end
                        end
                    end
                    default: begin
                        state_next = ST_OFF;
                        duty_next  = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_OFF;
                    duty_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    duty_reg  <= duty_next;
                end
            end

            // ON forces a solid output so full brightness has no one-cycle gap.
            assign lit[gi]    = (state_reg == ST_ON) || (pwm_cnt_reg < duty_reg);
            assign moving[gi] = (state_reg == ST_RISE) || (state_reg == ST_FALL);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledg_n_reg   <= 1'b1;
            ledr_n_reg   <= 1'b1;
            led_pmod_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            ledg_n_reg   <= ~lit[0];
            ledr_n_reg   <= ~lit[1];
            led_pmod_reg <= lit[6:2];
            busy_reg     <= |moving;
        end
    end

    assign ledg_n    = ledg_n_reg;
    assign ledr_n    = ledr_n_reg;
    assign led1      = led_pmod_reg[0];
    assign led2      = led_pmod_reg[1];
    assign led3      = led_pmod_reg[2];
    assign led4      = led_pmod_reg[3];
    assign led5      = led_pmod_reg[4];
    assign fade_busy = busy_reg;

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Output stage between the blink pattern logic and the iCEBreaker LED pins. Takes seven on/off LED requests and drives each pin through a PWM fade: a request turning on ramps brightness up linearly, and a request turning off ramps it down. The result is soft fades instead of hard blinks. Pin polarity is handled here, so upstream logic always uses 1 = lit.

## Interface
- PWM_BITS, 8, width of the PWM counter and of each duty register; PWM period = 2^PWM_BITS cycles
- FADE_DIV, 16, PWM periods per fade step (≥1)
- DUTY_STEP, 1, duty increment/decrement per fade step (≥1)

Ports:
- CLK  in  1  system clock (12 MHz on board)
- RST_N  in  1  reset, asynchronous assert, active-low
- LED_REQ  in  7  per-LED on request, 1 = lit; bit0→LEDG_N, bit1→LEDR_N, bits2..6→LED1..LED5
- LEDG_N  out  1  green LED, active-low
- LEDR_N  out  1  red LED, active-low
- LED1..LED5  out  1 each  PMOD LEDs, active-high
- FADE_BUSY  out  1  high while any LED is in RISE or FALL

## Operation
- pwm_cnt: PWM_BITS-wide, free-running, wraps 2^PWM_BITS-1 → 0.
- per_cnt: counts PWM periods 0..FADE_DIV-1. It advances on each pwm_cnt wrap and itself wraps to 0.
- tick: a 1-cycle pulse in the cycle where pwm_cnt == 2^PWM_BITS-1 and per_cnt == FADE_DIV-1.
- LED_REQ is registered into req_q, one cycle. All decisions use req_q.
- Each LED has a duty register (PWM_BITS wide) and a 2-bit state: OFF, RISE, ON, FALL. DUTY_MAX = 2^PWM_BITS-1.
- State transitions are evaluated every cycle:
  - OFF: req_q=1 → RISE.
  - RISE: req_q=0 → FALL, duty kept. On tick, duty = min(duty+DUTY_STEP, DUTY_MAX); if that result == DUTY_MAX → ON.
  - ON: req_q=0 → FALL.
  - FALL: req_q=1 → RISE, duty kept. On tick, duty = max(duty−DUTY_STEP, 0); if that result == 0 → OFF.
- Request change and tick in the same cycle: the direction change wins and duty is not updated that tick.
- Arithmetic is done at PWM_BITS+1 bits and then saturated, so duty never wraps.
- lit = (state==ON) OR (pwm_cnt < duty). ON is therefore a solid 100 %; duty 0 is never lit.
- Pin drive: LEDG_N = ~lit[0], LEDR_N = ~lit[1], LED1..LED5 = lit[2..6], all from output registers.
- FADE_BUSY is registered: OR over all LEDs of (state==RISE or FALL).

## Timing
- Reset (async assert, sync release): pwm_cnt=0, per_cnt=0, req_q=0, all duty=0, all states OFF. Outputs: LEDG_N=1, LEDR_N=1, LED1..LED5=0, FADE_BUSY=0.
- Reset mid-fade returns everything to OFF and duty 0 immediately, with no residual glow.
- Request to state change: LED_REQ edge → req_q at +1 → state at +2 → FADE_BUSY at +3.
- Duty to pin: a change in duty or pwm_cnt reaches the pin one cycle later (registered output).
- Full ramp: ceil(DUTY_MAX/DUTY_STEP) ticks. With defaults: 255 × 16 × 256 = 1,044,480 cycles ≈ 87 ms at 12 MHz.
- The first tick after reset occurs at cycle FADE_DIV·2^PWM_BITS − 1.
- Requests shorter than one tick still leave RISE then return via FALL. An OFF→RISE→FALL with duty still 0 reaches OFF at the next tick.

## Test plan
Directed cases use PWM_BITS=4, FADE_DIV=2, DUTY_STEP=1: period 16 cycles, tick every 32 cycles, full ramp 15 ticks = 480 cycles.
- Reset values: hold RST_N=0 for 5 cycles with LED_REQ=7'h7F → LEDG_N=LEDR_N=1, LED1..5=0, FADE_BUSY=0; all outputs stay at reset values while RST_N is low.
- Ramp up: release reset, set LED_REQ[2]=1 → FADE_BUSY goes high 3 cycles later. LED1 high-time per 16-cycle period goes 1, 2, … 15; after the 15th tick the state is ON, LED1 is solid 1, and FADE_BUSY=0.
- Ramp down and polarity: from ON, clear LED_REQ[0] → LEDG_N low-time per period goes 15 → 0 over 15 ticks, then LEDG_N stays 1 and FADE_BUSY=0.
- Reversal: raise LED_REQ[1] and drop it again after 5 ticks → duty peaks at 5 and falls 4, 3, 2, 1, 0; LEDR_N is never low for more than 5 cycles per period.
- Collision: toggle LED_REQ[3] so that req_q changes in the same cycle as a tick → duty is unchanged on that tick and the direction flips.
- Async reset mid-fade: assert RST_N at duty 7 between clock edges → outputs go to reset values before the next CLK edge; after release, duty restarts from 0.
